seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display (active-low segments and anodes).

---
 rtl/seven_seg_scan_driver.sv | 177 +++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed driver for a common-anode 7-segment
// display. One digit is lit per prescaler slot. A newly loaded word waits in a
// pending buffer and only becomes active at a frame boundary, so a frame never
// mixes digits from two different words.
// The glyph table is written in abcdefg reading order (segment a is the leftmost
// character); to_seg() maps it onto the pins, where seg[0]=a and seg[6]=g.
module seven_seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int CLK_DIV  = 50000,
  parameter bit HEX_MODE = 1'b0,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                load,
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]   dp_in,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp_n,
  output logic                frame
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'b1111111;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_word_q, pend_word_d, act_word_q, act_word_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                pend_q, pend_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic                frame_q, frame_d;
  logic                tick, boundary;

  // Glyph in abcdefg order, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001101;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = HEX_MODE ? 7'b0001000 : 7'b1111110;
      4'hB:    g = HEX_MODE ? 7'b1100000 : 7'b1111110;
      4'hC:    g = HEX_MODE ? 7'b0110001 : 7'b1111110;
      4'hD:    g = HEX_MODE ? 7'b1000010 : 7'b1111110;
      4'hE:    g = HEX_MODE ? 7'b0110000 : 7'b1111110;
      default: g = HEX_MODE ? 7'b0111000 : 7'b1111110;
    endcase
    return g;
  endfunction

  // abcdefg reading order -> pin order (seg[0]=a).
  function automatic logic [6:0] to_seg(input logic [6:0] abcdefg);
    logic [6:0] s;
    for (int k = 0; k < 7; k++) begin
      s[k] = abcdefg[6-k];
    end
    return s;
  endfunction

  // Prescaler, scan index and double-buffered word: next-state logic.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pend_word_d = pend_word_q;
    pend_dp_d   = pend_dp_q;
    pend_d      = pend_q;
    act_word_d  = act_word_q;
    act_dp_d    = act_dp_q;
    tick        = enable && (cnt_q == CNT_LAST);
    boundary    = tick && (idx_q == IDX_LAST);
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
    if (tick) begin
      idx_d = boundary ? '0 : idx_q + IDX_W'(1);
    end
    if (load) begin
      pend_word_d = digits_in;
      pend_dp_d   = dp_in;
      pend_d      = 1'b1;
    end
    if (boundary) begin
      // A load on the boundary cycle goes straight into the new frame.
      if (load) begin
        act_word_d = digits_in;
        act_dp_d   = dp_in;
      end else if (pend_q) begin
        act_word_d = pend_word_q;
        act_dp_d   = pend_dp_q;
      end
      pend_d = 1'b0;
    end
  end

  // Per-digit nibble and "this nibble and everything above it is zero" flag.
  logic [3:0]        nib_d [DIGITS];
  logic [DIGITS-1:0] lz_d;
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib_d[gi] = act_word_d[4*gi +: 4];
      assign lz_d[gi]  = (act_word_d[4*DIGITS-1:4*gi] == '0);
    end
  endgenerate

  // Display outputs: blank while disabled, refresh on a tick, otherwise hold.
  always_comb begin
    an_d    = an_q;
    seg_d   = seg_q;
    dp_n_d  = dp_n_q;
    frame_d = 1'b0;
    if (!enable) begin
      an_d   = '1;
      seg_d  = SEG_OFF;
      dp_n_d = 1'b1;
    end else if (tick) begin
      an_d = ~(DIGITS'(1) << idx_d);
      if (BLANK_LZ && (idx_d != '0) && lz_d[idx_d]) begin
        seg_d = SEG_OFF;
      end else begin
        seg_d = to_seg(glyph(nib_d[idx_d]));
      end
      dp_n_d  = ~act_dp_d[idx_d];
      frame_d = boundary;
    end
  end

  // State registers; reset takes effect immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= IDX_LAST;
      pend_word_q <= '0;
      pend_dp_q   <= '0;
      pend_q      <= 1'b0;
      act_word_q  <= '0;
      act_dp_q    <= '0;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      dp_n_q      <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_word_q <= pend_word_d;
      pend_dp_q   <= pend_dp_d;
      pend_q      <= pend_d;
      act_word_q  <= act_word_d;
      act_dp_q    <= act_dp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      frame_q     <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp_n  = dp_n_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two instances (decimal / no blanking and
// hex / leading-zero blanking) share one stimulus stream. A reference model
// pushes the expected display state per clock into a queue; a monitor pops it.
module tb_seven_seg_scan_driver;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_n_a, dp_n_b, frame_a, frame_b;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .HEX_MODE(1'b0), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .reset(rst), .enable(enable), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .an(an_a), .seg(seg_a), .dp_n(dp_n_a), .frame(frame_a));

  seven_seg_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .HEX_MODE(1'b1), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .reset(rst), .enable(enable), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .an(an_b), .seg(seg_b), .dp_n(dp_n_b), .frame(frame_b));

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic       dp_n;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Glyph table in abcdefg reading order (0..9, then hex A..F).
  logic [6:0] glyph_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001101, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reading order -> pin vector, seg[0]=a.
  function automatic logic [6:0] seg_of(input logic [6:0] abcdefg);
    logic [6:0] s;
    for (int k = 0; k < 7; k++) s[k] = abcdefg[6-k];
    return s;
  endfunction

  function automatic logic [6:0] ref_glyph(input int nib, input bit hex);
    if (nib >= 10 && !hex) return seg_of(7'b1111110);
    return seg_of(glyph_tbl[nib]);
  endfunction

  // ---------------- reference model ----------------
  int          en_cycles;   // enabled clocks since reset
  int          ticks;       // digit slots started since reset
  logic [15:0] latest_word, shown_word;
  logic [3:0]  latest_dp, shown_dp;
  exp_t        cur;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        en_cycles = 0; ticks = 0;
        latest_word = '0; latest_dp = '0; shown_word = '0; shown_dp = '0;
        cur = '{an: 4'hF, seg_a: 7'h7F, seg_b: 7'h7F, dp_n: 1'b1, frame: 1'b0};
      end else begin
        if (load) begin
          latest_word = digits_in;
          latest_dp   = dp_in;
        end
        cur.frame = 1'b0;
        if (!enable) begin
          cur = '{an: 4'hF, seg_a: 7'h7F, seg_b: 7'h7F, dp_n: 1'b1, frame: 1'b0};
        end else begin
          if (en_cycles % CLK_DIV == CLK_DIV - 1) begin
            int d;
            int nib;
            d = ticks % DIGITS;
            ticks++;
            if (d == 0) begin
              shown_word = latest_word;
              shown_dp   = latest_dp;
              cur.frame  = 1'b1;
            end
            cur.an    = 4'hF;
            cur.an[d] = 1'b0;
            nib       = int'((shown_word >> (4 * d)) & 16'hF);
            cur.seg_a = ref_glyph(nib, 1'b0);
            cur.seg_b = (d > 0 && (shown_word >> (4 * d)) == 16'd0) ? 7'h7F : ref_glyph(nib, 1'b1);
            cur.dp_n  = !shown_dp[d];
          end
          en_cycles++;
        end
      end
      exp_q.push_back(cur);
    end
  end

  // An asynchronous reset invalidates whatever was predicted for this cycle.
  initial begin
    forever begin
      @(posedge rst);
      exp_q.delete();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (an_a !== e.an || an_b !== e.an || seg_a !== e.seg_a || seg_b !== e.seg_b ||
            dp_n_a !== e.dp_n || dp_n_b !== e.dp_n || frame_a !== e.frame || frame_b !== e.frame) begin
          fails++;
          $display("FAIL scan t=%0t an=%b/%b req %b seg=%b/%b req %b/%b dp_n=%b/%b req %b frame=%b/%b req %b",
                   $time, an_a, an_b, e.an, seg_a, seg_b, e.seg_a, e.seg_b,
                   dp_n_a, dp_n_b, e.dp_n, frame_a, frame_b, e.frame);
        end
      end
    end
  end

  // ---------------- directed spot checks ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] w, input logic [3:0] dp);
    load = 1'b1; digits_in = w; dp_in = dp;
    $display("[TB] load word=%h dp=%b t=%0t", w, dp, $time);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", 16'(an_a), 16'hF);
    check("async_rst_seg", 16'(seg_a), 16'h7F);
    check("async_rst_dp", 16'(dp_n_a), 16'h1);
    $display("[TB] async reset t=%0t", $time);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'hF0F0};
    rst = 1'b1; enable = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
    cyc(2);
    check("reset_an", 16'(an_a), 16'hF);
    check("reset_seg", 16'(seg_a), 16'h7F);
    check("reset_frame", 16'(frame_a), 16'h0);

    // First word; first tick lands three clocks after the load cycle.
    rst = 1'b0; enable = 1'b1;
    do_load(16'h1234, 4'b0000);
    cyc(1); load = 1'b0;
    cyc(3);
    check("t1_an_d0", 16'(an_a), 16'b1110);
    check("t1_seg_d0", 16'(seg_a), 16'(seg_of(7'b1001100)));
    check("t1_frame", 16'(frame_a), 16'h1);
    cyc(1);
    check("t1_frame_low", 16'(frame_a), 16'h0);
    cyc(3);
    check("t1_an_d1", 16'(an_a), 16'b1101);
    check("t1_seg_d1", 16'(seg_a), 16'(seg_of(7'b0000110)));

    // Mid-frame load is held back until the next boundary.
    do_load(16'h5678, 4'b0000);
    cyc(1); load = 1'b0;
    cyc(3);
    check("t2_seg_d2_old", 16'(seg_a), 16'(seg_of(7'b0010010)));
    cyc(4);
    check("t2_seg_d3_old", 16'(seg_a), 16'(seg_of(7'b1001111)));
    cyc(4);
    check("t2_seg_d0_new", 16'(seg_a), 16'(seg_of(7'b0000000)));

    // Load on the boundary cycle itself.
    cyc(15);
    do_load(16'h00B9, 4'b0001);
    cyc(1); load = 1'b0;
    check("t3_seg_d0", 16'(seg_a), 16'(seg_of(7'b0000100)));
    check("t3_dp_d0", 16'(dp_n_a), 16'h0);
    cyc(4);
    check("t5_dec_B", 16'(seg_a), 16'(seg_of(7'b1111110)));
    check("t5_hex_B", 16'(seg_b), 16'(seg_of(7'b1100000)));

    // Leading-zero blanking on dut_b.
    do_load(16'h0070, 4'b0100);
    cyc(1); load = 1'b0;
    cyc(11);
    check("t4_d0_zero", 16'(seg_b), 16'(seg_of(7'b0000001)));
    cyc(4);
    check("t4_d1_seven", 16'(seg_b), 16'(seg_of(7'b0001101)));
    cyc(4);
    check("t4_d2_blank", 16'(seg_b), 16'h7F);
    check("t4_d2_dp", 16'(dp_n_b), 16'h0);
    check("t4_d2_an", 16'(an_b), 16'b1011);
    cyc(4);
    check("t4_d3_blank", 16'(seg_b), 16'h7F);
    check("t4_d3_dp", 16'(dp_n_b), 16'h1);

    // Freeze for ten clocks mid-slot, then resume.
    cyc(2);
    enable = 1'b0;
    cyc(1);
    check("t6_freeze_an", 16'(an_a), 16'hF);
    cyc(9);
    enable = 1'b1;
    cyc(6);
    async_reset();

    // Randomised traffic.
    enable = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) begin
        do_load(16'($urandom) & masks[$urandom_range(0, 4)], 4'($urandom));
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) async_reset();
    end
    load = 1'b0;
    cyc(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
